// File: rtl/spi_reg_ctrl.sv
// SPI mode-0 target turning wr/addr/data frames into register bank accesses.
// Optional burst mode with address auto-increment: define SPI_ADDR_AUTOINC_EN.
module spi_reg_ctrl #(
    parameter int REG_W       = 8,
    parameter int ADDR_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_cs_n,
    input  logic              spi_sclk,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic              req,
    output logic              wr_rdn,
    output logic [ADDR_W-1:0] addr,
    output logic [REG_W-1:0]  wdata,
    output logic              we,
    input  logic [REG_W-1:0]  rdata,
    input  logic              ack,
    input  logic              err,
    output logic              err_sticky,
    output logic              busy
);
    localparam int CW = $clog2(ADDR_W + REG_W + 1);
`ifdef SPI_ADDR_AUTOINC_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE, CMD, RD_REQ, RD_DATA, WR_DATA, WR_REQ, DONE
    } state_t;

    state_t state, state_nx;

    logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, mosi_sync;
    logic              sclk_q, sclk_rise, sclk_fall, mosi_s;
    logic              cs_act, cs_q, late, late_now;
    logic [CW-1:0]     cnt;
    logic [ADDR_W-1:0] cmd_sh;
    logic [REG_W-1:0]  rx, tx;
    logic              last_cmd, last_wr, rd_end;

    assign last_cmd = (state == CMD) && sclk_rise && (cnt == CW'(ADDR_W));
    assign last_wr  = (state == WR_DATA) && sclk_rise && (cnt == CW'(REG_W - 1));
    // Rises seen while waiting for a late ack count toward the data field
    assign rd_end   = (state == RD_DATA) &&
                      ((sclk_rise && (cnt == CW'(REG_W - 1))) || (cnt >= CW'(REG_W)));
    assign late_now = late | sclk_fall;

    assign wdata       = rx;
    assign spi_miso_oe = cs_act;
    assign busy        = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        req      = 1'b0;
        we       = 1'b0;
        wr_rdn   = 1'b0;
        unique case (state)
            IDLE: if (cs_act && !cs_q) state_nx = CMD;
            CMD: begin
                if (!cs_act)       state_nx = IDLE;
                else if (last_cmd) state_nx = cmd_sh[ADDR_W-1] ? WR_DATA : RD_REQ;
            end
            RD_REQ: begin
                req = 1'b1;
                if (!cs_act)  state_nx = IDLE;
                else if (ack) state_nx = RD_DATA;
            end
            RD_DATA: begin
                if (!cs_act)     state_nx = IDLE;
                else if (rd_end) state_nx = BURST ? RD_REQ : DONE;
            end
            WR_DATA: begin
                if (!cs_act)      state_nx = IDLE;
                else if (last_wr) state_nx = WR_REQ;
            end
            WR_REQ: begin
                req    = 1'b1;
                we     = 1'b1;
                wr_rdn = 1'b1;
                // An issued write always completes, even if CS has dropped
                if (ack) state_nx = !cs_act ? IDLE : (BURST ? WR_DATA : DONE);
            end
            DONE: if (!cs_act) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_sync    <= '1;
            sclk_sync  <= '0;
            mosi_sync  <= '0;
            sclk_q     <= 1'b0;
            sclk_rise  <= 1'b0;
            sclk_fall  <= 1'b0;
            mosi_s     <= 1'b0;
            cs_act     <= 1'b0;
            cs_q       <= 1'b0;
            late       <= 1'b0;
            cnt        <= '0;
            cmd_sh     <= '0;
            rx         <= '0;
            tx         <= '0;
            addr       <= '0;
            spi_miso   <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sclk_q    <= sclk_sync[SYNC_STAGES-1];
            sclk_rise <= sclk_sync[SYNC_STAGES-1] & ~sclk_q;
            sclk_fall <= ~sclk_sync[SYNC_STAGES-1] & sclk_q;
            mosi_s    <= mosi_sync[SYNC_STAGES-1];
            cs_act    <= ~cs_sync[SYNC_STAGES-1];
            cs_q      <= cs_act;
            if (req && ack && err) err_sticky <= 1'b1;
            unique case (state)
                IDLE: cnt <= '0;
                CMD: begin
                    if (sclk_rise) begin
                        cmd_sh <= {cmd_sh[ADDR_W-2:0], mosi_s};
                        cnt    <= last_cmd ? '0 : cnt + 1'b1;
                    end
                    if (last_cmd) addr <= {cmd_sh[ADDR_W-2:0], mosi_s};
                end
                RD_REQ: begin
                    if (sclk_rise) cnt <= cnt + 1'b1;
                    if (sclk_fall) late <= 1'b1;
                    // Host already clocked past the first bit: send zeros
                    if (ack) begin
                        tx <= late_now ? '0 : rdata;
                        if (late_now) err_sticky <= 1'b1;
                    end
                end
                RD_DATA: begin
                    if (rd_end)         cnt <= '0;
                    else if (sclk_rise) cnt <= cnt + 1'b1;
                    if (sclk_fall) begin
                        spi_miso <= tx[REG_W-1];
                        tx       <= tx << 1;
                    end
                    if (rd_end && BURST && cs_act) addr <= addr + 1'b1;
                end
                WR_DATA: begin
                    if (sclk_rise) begin
                        rx  <= {rx[REG_W-2:0], mosi_s};
                        cnt <= last_wr ? '0 : cnt + 1'b1;
                    end
                end
                WR_REQ: if (ack && BURST && cs_act) addr <= addr + 1'b1;
                default: ;
            endcase
            if (state != RD_DATA) spi_miso <= 1'b0;
            if (state != RD_REQ)  late <= 1'b0;
        end
    end
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Bench for spi_reg_ctrl: SPI host driver, bank model and expected-memory model.
// Burst expectations are selected by SPI_ADDR_AUTOINC_EN.
module tb_spi_reg_ctrl;
    localparam int H = 8;
`ifdef SPI_ADDR_AUTOINC_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, spi_cs_n, spi_sclk, spi_mosi;
    logic       spi_miso, spi_miso_oe, req, wr_rdn, we, ack, err;
    logic       err_sticky, busy;
    logic [7:0] addr, wdata, rdata;

    typedef struct {
        bit         wr;
        logic [7:0] a;
        logic [7:0] d;
        bit         we;
    } acc_t;

    acc_t       acc_q[$];
    logic [7:0] mem [256];
    bit         vld [256];
    logic [7:0] ref_mem [256];
    int         checks = 0, failures = 0;
    int         req_cyc = 0, req_age = 0, ack_dly = 0;
    bit         err_cfg = 0, exp_sticky = 0, force_en = 0;
    logic [7:0] force_val = 8'h00;

    always #5 clk = ~clk;

    spi_reg_ctrl #(.REG_W(8), .ADDR_W(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .req(req), .wr_rdn(wr_rdn), .addr(addr), .wdata(wdata), .we(we),
        .rdata(rdata), .ack(ack), .err(err), .err_sticky(err_sticky),
        .busy(busy)
    );

    function automatic logic [7:0] pre(input logic [7:0] a);
        return (a * 8'd37) ^ 8'h5A;
    endfunction

    // Bank model: acks after ack_dly wait cycles, stores writes
    assign ack   = req && (req_age >= ack_dly);
    assign err   = err_cfg;
    assign rdata = force_en ? force_val : (vld[addr] ? mem[addr] : pre(addr));

    always @(posedge clk) req_age <= (req && !ack) ? req_age + 1 : 0;

    always @(negedge clk) begin
        if (req) req_cyc++;
        if (req && ack) begin
            acc_q.push_back('{wr_rdn, addr, wdata, we});
            if (we) begin
                mem[addr] = wdata;
                vld[addr] = 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic spi_bits(input int n, input logic [31:0] dout, output logic [31:0] din);
        din = '0;
        for (int i = n - 1; i >= 0; i--) begin
            spi_mosi = dout[i];
            repeat (H) @(negedge clk);
            spi_sclk = 1'b1;
            din = {din[30:0], spi_miso};
            repeat (H) @(negedge clk);
            spi_sclk = 1'b0;
        end
        spi_mosi = 1'b0;
    endtask

    task automatic run_frame(input bit wr, input logic [7:0] a, input logic [7:0] d, input int dly);
        logic [31:0] din;
        logic [7:0]  exp_rd;
        int          q0, r0, exp_n;
        ack_dly    = dly;
        q0         = acc_q.size();
        r0         = req_cyc;
        exp_rd     = ref_mem[a];
        exp_n      = 1 + int'(BURST && !wr);
        exp_sticky = exp_sticky | err_cfg;
        if (wr) ref_mem[a] = d;
        spi_cs_n = 1'b0;
        repeat (H) @(negedge clk);
        spi_bits(17, {15'b0, wr, a, d}, din);
        repeat (H) @(negedge clk);
        check("frm_busy_in_frame", busy, 1);
        spi_cs_n = 1'b1;
        repeat (2 * H) @(negedge clk);
        check("frm_acc_count", acc_q.size() - q0, exp_n);
        if (acc_q.size() > q0) begin
            check("frm_acc_wr", acc_q[q0].wr, wr);
            check("frm_acc_we", acc_q[q0].we, wr);
            check("frm_acc_addr", acc_q[q0].a, a);
            if (wr) check("frm_acc_wdata", acc_q[q0].d, d);
        end
        check("frm_req_cycles", req_cyc - r0, exp_n * (dly + 1));
        if (!wr) check("frm_miso_byte", din[7:0], exp_rd);
        check("frm_addr_hold", addr, a + 8'(BURST));
        check("frm_sticky", err_sticky, exp_sticky);
        check("frm_idle", busy, 0);
    endtask

    initial begin
        logic [31:0] din;
        int          q0, r0;
        bit          wr;
        logic [7:0]  a, d;
        for (int i = 0; i < 256; i++) ref_mem[i] = pre(8'(i));
        rst = 1'b1; spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_miso", spi_miso, 0);
        check("rst_miso_oe", spi_miso_oe, 0);
        check("rst_req", req, 0);
        check("rst_we", we, 0);
        check("rst_wr_rdn", wr_rdn, 0);
        check("rst_addr", addr, 0);
        check("rst_wdata", wdata, 0);
        check("rst_sticky", err_sticky, 0);
        check("rst_busy", busy, 0);

        run_frame(1'b1, 8'h03, 8'h5A, 0);

        // Status-space read with fixed bank data 0xC3
        force_en = 1'b1; force_val = 8'hC3;
        q0 = acc_q.size(); r0 = req_cyc; ack_dly = 0;
        spi_cs_n = 1'b0;
        repeat (H) @(negedge clk);
        spi_bits(17, {15'b0, 1'b0, 8'h83, 8'h00}, din);
        repeat (H) @(negedge clk);
        check("rd_oe_active", spi_miso_oe, 1);
        spi_cs_n = 1'b1;
        repeat (2 * H) @(negedge clk);
        force_en = 1'b0;
        check("rd_miso_c3", din[7:0], 8'hC3);
        check("rd_acc_count", acc_q.size() - q0, 1 + int'(BURST));
        if (acc_q.size() > q0) check("rd_acc_we", acc_q[q0].we, 0);
        check("rd_oe_idle", spi_miso_oe, 0);

        for (int n = 0; n < 24; n++) begin
            wr = 1'($urandom);
            a  = ($urandom % 2 == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
            d  = 8'($urandom);
            run_frame(wr, a, d, int'($urandom_range(0, 3)));
        end

        // Abort a write after 5 data bits
        q0 = acc_q.size();
        spi_cs_n = 1'b0;
        repeat (H) @(negedge clk);
        spi_bits(14, {18'b0, 1'b1, 8'h21, 5'b10101}, din);
        spi_cs_n = 1'b1;
        repeat (2 * H) @(negedge clk);
        check("abort_no_access", acc_q.size() - q0, 0);
        check("abort_idle", busy, 0);
        run_frame(1'b0, 8'h21, 8'h00, 1);

        // Ack after 3 wait cycles with err
        err_cfg = 1'b1;
        run_frame(1'b1, 8'h44, 8'hA5, 3);
        err_cfg = 1'b0;
        run_frame(1'b0, 8'h44, 8'h00, 0);

        // Reset pulsed in the read data phase
        spi_cs_n = 1'b0;
        repeat (H) @(negedge clk);
        spi_bits(12, {20'b0, 1'b0, 8'h83, 3'b000}, din);
        check("mid_busy", busy, 1);
        rst = 1'b1;
        spi_cs_n = 1'b1;
        @(negedge clk);
        check("mid_miso", spi_miso, 0);
        check("mid_miso_oe", spi_miso_oe, 0);
        check("mid_req", req, 0);
        check("mid_we", we, 0);
        check("mid_addr", addr, 0);
        check("mid_wdata", wdata, 0);
        check("mid_sticky", err_sticky, 0);
        check("mid_busy_rst", busy, 0);
        rst = 1'b0;
        exp_sticky = 1'b0;
        repeat (2 * H) @(negedge clk);

        // Late ack: host clocks out the data field before the bank answers
        q0 = acc_q.size(); ack_dly = 40;
        spi_cs_n = 1'b0;
        repeat (H) @(negedge clk);
        spi_bits(17, {15'b0, 1'b0, 8'h05, 8'h00}, din);
        repeat (H) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (2 * H) @(negedge clk);
        check("late_miso_zero", din[7:0], 0);
        check("late_sticky", err_sticky, 1);
        check("late_acc_count", acc_q.size() - q0, 1);
        exp_sticky = 1'b1;

        // Write 0x11, 0x22 starting at 0xFF
        q0 = acc_q.size(); ack_dly = 0;
        spi_cs_n = 1'b0;
        repeat (H) @(negedge clk);
        spi_bits(25, {7'b0, 1'b1, 8'hFF, 8'h11, 8'h22}, din);
        repeat (H) @(negedge clk);
        check("burst_miso_zero", din[15:0], 0);
        spi_cs_n = 1'b1;
        repeat (2 * H) @(negedge clk);
`ifdef SPI_ADDR_AUTOINC_EN
        check("burst_acc_count", acc_q.size() - q0, 2);
        if (acc_q.size() > q0 + 1) begin
            check("burst_a0", acc_q[q0].a, 8'hFF);
            check("burst_d0", acc_q[q0].d, 8'h11);
            check("burst_a1", acc_q[q0 + 1].a, 8'h00);
            check("burst_d1", acc_q[q0 + 1].d, 8'h22);
        end
        ref_mem[8'h00] = 8'h22;
`else
        check("single_acc_count", acc_q.size() - q0, 1);
        if (acc_q.size() > q0) begin
            check("single_a0", acc_q[q0].a, 8'hFF);
            check("single_d0", acc_q[q0].d, 8'h11);
        end
`endif
        ref_mem[8'hFF] = 8'h11;
        run_frame(1'b0, 8'hFF, 8'h00, 0);
        run_frame(1'b0, 8'h00, 8'h00, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
